// File: rtl/y86_stage_sequencer.sv
// y86_stage_sequencer: multi-cycle Y86 control FSM sequencing fetch..writeback and PC update.
// Optional performance counters are built only when PERF_CNT_EN is defined.
module y86_stage_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [3:0]  icode,
  input  logic        instr_valid,
  input  logic        imem_error,
  input  logic        dmem_error,
  input  logic        mem_ready,
  input  logic        cnd,
  input  logic [63:0] valP,
  input  logic [63:0] valC,
  input  logic [63:0] valM,
  output logic        fetch_en,
  output logic        decode_en,
  output logic        exec_en,
  output logic        mem_en,
  output logic        wb_en,
  output logic [63:0] PC,
  output logic [2:0]  stat,
  output logic        halted,
  output logic [31:0] retired_cnt,
  output logic [31:0] cycle_cnt
);
  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, PCUPD, HALT} state_e;
  localparam logic [2:0] AOK = 3'd1, HLT = 3'd2, ADR = 3'd3, INS = 3'd4;
  state_e      state_q, state_d;
  logic [63:0] pc_q, pc_d, next_pc;
  logic [2:0]  stat_q, stat_d;
  logic [3:0]  icode_q, icode_d;
  assign next_pc = icode_q == 4'd7 ? (cnd ? valC : valP) :
                   icode_q == 4'd8 ? valC :
                   icode_q == 4'd9 ? valM : valP;
  always_comb begin
    state_d = state_q;
    stat_d  = stat_q;
    pc_d    = pc_q;
    icode_d = icode_q;
    case (state_q)
      IDLE:      state_d = start ? FETCH : IDLE;
      FETCH: begin
        icode_d = icode;
        state_d = (imem_error || !instr_valid || icode == 4'd0) ? HALT : DECODE;
        stat_d  = imem_error ? ADR : !instr_valid ? INS : icode == 4'd0 ? HLT : AOK;
      end
      DECODE:    state_d = EXECUTE;
      EXECUTE:   state_d = MEMORY;
      MEMORY: begin
        state_d = dmem_error ? HALT : mem_ready ? WRITEBACK : MEMORY;
        stat_d  = dmem_error ? ADR : AOK;
      end
      WRITEBACK: state_d = PCUPD;
      PCUPD: begin
        state_d = FETCH;
        pc_d    = next_pc;
      end
      default:   state_d = HALT;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= '0;
      stat_q  <= AOK;
      icode_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      stat_q  <= stat_d;
      icode_q <= icode_d;
    end
  end
  assign fetch_en  = state_q == FETCH;
  assign decode_en = state_q == DECODE;
  assign exec_en   = state_q == EXECUTE;
  assign mem_en    = state_q == MEMORY;
  assign wb_en     = state_q == WRITEBACK;
  assign halted    = state_q == HALT;
  assign PC        = pc_q;
  assign stat      = stat_q;
`ifdef PERF_CNT_EN
  logic [31:0] ret_q, cyc_q;
  // both counters stick at all-ones instead of wrapping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ret_q <= '0;
      cyc_q <= '0;
    end else begin
      if (state_q == PCUPD && ret_q != '1) ret_q <= ret_q + 32'd1;
      if (state_q != IDLE && state_q != HALT && cyc_q != '1) cyc_q <= cyc_q + 32'd1;
    end
  end
  assign retired_cnt = ret_q;
  assign cycle_cnt   = cyc_q;
`else
  assign retired_cnt = '0;
  assign cycle_cnt   = '0;
`endif
endmodule

// File: tb/tb_y86_stage_sequencer.sv
// tb_y86_stage_sequencer: directed stimulus pushes per-cycle expectations; a monitor pops and compares.
module tb_y86_stage_sequencer;
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_EXECUTE, S_MEMORY, S_WB, S_PCUPD, S_HALT} st_e;
  typedef struct {
    logic [4:0]  en;
    logic [63:0] pc;
    logic [2:0]  stat;
    logic        halted;
    logic [31:0] ret;
    logic [31:0] cyc;
  } exp_t;
  logic clk = 0, rst, start, instr_valid, imem_error, dmem_error, mem_ready, cnd;
  logic [3:0] icode;
  logic [63:0] valP, valC, valM, PC;
  logic fetch_en, decode_en, exec_en, mem_en, wb_en, halted;
  logic [2:0] stat;
  logic [31:0] retired_cnt, cycle_cnt;
  exp_t q[$];
  exp_t e;
  st_e ep = S_IDLE;
  logic [31:0] er = 0, ec = 0;
  int checks = 0, errors = 0;

  y86_stage_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .icode(icode), .instr_valid(instr_valid),
    .imem_error(imem_error), .dmem_error(dmem_error), .mem_ready(mem_ready), .cnd(cnd),
    .valP(valP), .valC(valC), .valM(valM),
    .fetch_en(fetch_en), .decode_en(decode_en), .exec_en(exec_en), .mem_en(mem_en), .wb_en(wb_en),
    .PC(PC), .stat(stat), .halted(halted), .retired_cnt(retired_cnt), .cycle_cnt(cycle_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or posedge rst) begin
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      check("enables", {59'd0, fetch_en, decode_en, exec_en, mem_en, wb_en}, {59'd0, e.en});
      check("PC", PC, e.pc);
      check("stat", {61'd0, stat}, {61'd0, e.stat});
      check("halted", {63'd0, halted}, {63'd0, e.halted});
      check("retired_cnt", {32'd0, retired_cnt}, {32'd0, e.ret});
      check("cycle_cnt", {32'd0, cycle_cnt}, {32'd0, e.cyc});
    end
  end

  // expected outputs right after the next clock edge (or right after an async reset)
  task automatic push(input st_e s, input logic [63:0] pc, input logic [2:0] st);
    exp_t x;
    if (rst) begin
      er = 0;
      ec = 0;
    end else begin
      if (ep == S_PCUPD) er++;
      if (ep != S_IDLE && ep != S_HALT) ec++;
    end
    x.en = s == S_FETCH ? 5'b10000 : s == S_DECODE ? 5'b01000 : s == S_EXECUTE ? 5'b00100 :
           s == S_MEMORY ? 5'b00010 : s == S_WB ? 5'b00001 : 5'b00000;
    x.pc = pc;
    x.stat = st;
    x.halted = s == S_HALT;
`ifdef PERF_CNT_EN
    x.ret = er;
    x.cyc = ec;
`else
    x.ret = 0;
    x.cyc = 0;
`endif
    q.push_back(x);
    ep = s;
  endtask

  task automatic step(input st_e s, input logic [63:0] pc, input logic [2:0] st);
    push(s, pc, st);
    @(negedge clk);
  endtask

  task automatic do_reset;
    rst = 1;
    start = 0;
    imem_error = 0;
    dmem_error = 0;
    instr_valid = 1;
    mem_ready = 1;
    cnd = 0;
    @(negedge clk);
    push(S_IDLE, 0, 3'd1);
    @(negedge clk);
    rst = 0;
    ep = S_IDLE;
  endtask

  task automatic kick(input logic [63:0] pc);
    start = 1;
    step(S_FETCH, pc, 3'd1);
    start = 0;
  endtask

  // from FETCH through PCUPD back to FETCH; waits = cycles with mem_ready low
  task automatic instr(input logic [63:0] pc0, input logic [63:0] pc1, input int waits);
    step(S_DECODE, pc0, 3'd1);
    step(S_EXECUTE, pc0, 3'd1);
    step(S_MEMORY, pc0, 3'd1);
    mem_ready = 0;
    repeat (waits) step(S_MEMORY, pc0, 3'd1);
    mem_ready = 1;
    step(S_WB, pc0, 3'd1);
    step(S_PCUPD, pc0, 3'd1);
    step(S_FETCH, pc1, 3'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    rst = 1; start = 0; icode = 0; instr_valid = 0; imem_error = 0; dmem_error = 0;
    mem_ready = 0; cnd = 0; valP = 0; valC = 0; valM = 0;
    do_reset;
    // sequential op
    icode = 4'd6; valP = 64'h2; valC = 64'h77; valM = 64'h55;
    kick(0);
    instr(0, 64'h2, 0);
    // conditional jump not taken then taken
    do_reset;
    icode = 4'd7; cnd = 0; valC = 64'h40; valP = 64'h9;
    kick(0);
    instr(0, 64'h9, 0);
    cnd = 1; valP = 64'h12;
    instr(64'h9, 64'h40, 0);
    cnd = 0;
    // ret-style load from valM with memory wait states
    do_reset;
    icode = 4'd9; valM = 64'h100; valP = 64'hA; valC = 64'h33;
    kick(0);
    instr(0, 64'h100, 3);
    // jump to 0x20, then halt there; start ignored afterwards
    do_reset;
    icode = 4'd8; valC = 64'h20; valP = 64'h5;
    kick(0);
    instr(0, 64'h20, 0);
    icode = 4'd0; valP = 64'h99;
    step(S_HALT, 64'h20, 3'd2);
    start = 1;
    step(S_HALT, 64'h20, 3'd2);
    step(S_HALT, 64'h20, 3'd2);
    start = 0;
    // fetch error priority: imem_error beats invalid and icode 0
    do_reset;
    kick(0);
    imem_error = 1; instr_valid = 0; icode = 4'd0;
    step(S_HALT, 0, 3'd3);
    do_reset;
    kick(0);
    instr_valid = 0; icode = 4'd0;
    step(S_HALT, 0, 3'd4);
    // dmem_error in MEMORY halts even with mem_ready high
    do_reset;
    icode = 4'd5; valP = 64'h7;
    kick(0);
    step(S_DECODE, 0, 3'd1);
    step(S_EXECUTE, 0, 3'd1);
    step(S_MEMORY, 0, 3'd1);
    dmem_error = 1;
    step(S_HALT, 0, 3'd3);
    dmem_error = 0;
    step(S_HALT, 0, 3'd3);
    // async reset mid-EXECUTE, then restart only via start
    do_reset;
    icode = 4'd6; valP = 64'h4;
    kick(0);
    step(S_DECODE, 0, 3'd1);
    step(S_EXECUTE, 0, 3'd1);
    #2;
    rst = 1;
    push(S_IDLE, 0, 3'd1);
    push(S_IDLE, 0, 3'd1);
    @(negedge clk);
    rst = 0;
    ep = S_IDLE;
    step(S_IDLE, 0, 3'd1);
    step(S_IDLE, 0, 3'd1);
    kick(0);
    instr(0, 64'h4, 0);
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
